// File: rtl/jk_pkg.sv
// Shared types for the JK command front-end: FSM states, command encodings
// and a counter-width helper.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PAIR = 2'b01,
    EMIT = 2'b10,
    LOCK = 2'b11
  } jk_state_e;

  // bit1 drives oJ, bit0 drives oK
  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/jk_debounce.sv
// One button channel: synchroniser chain, stable-count debounce and a
// one-cycle rising-edge event on the debounced level.
module jk_debounce
  import jk_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   level_q;
  logic                   level_d;
  logic                   level_prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // The flip happens on the cycle the count would reach DEBOUNCE_CYCLES,
  // so the counter itself never needs to hold that value.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/jk_cmd_gen.sv
// Turns debounced SET/CLR presses into one-cycle J/K command pulses,
// merging two presses inside the pairing window into a toggle.
module jk_cmd_gen
  import jk_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PAIR_WINDOW     = 1000
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtnSet,
  input  logic iBtnClr,
  output logic oJ,
  output logic oK,
  output logic oBusy
);

  localparam int WW = cnt_width(PAIR_WINDOW);
  localparam logic [WW-1:0] WIN_LAST = (PAIR_WINDOW > 0) ? WW'(PAIR_WINDOW - 1) : '0;

  logic lvl_set;
  logic lvl_clr;
  logic rise_set;
  logic rise_clr;
  logic other_rise;

  jk_state_e   state_q;
  jk_state_e   state_d;
  logic [1:0]  pend_q;
  logic [1:0]  pend_d;
  logic [WW-1:0] wcnt_q;
  logic [WW-1:0] wcnt_d;
  logic [1:0]  jk_q;
  logic [1:0]  jk_d;
  logic        busy_q;
  logic        busy_d;

  jk_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_set (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .btn_i   (iBtnSet),
    .level_o (lvl_set),
    .rise_o  (rise_set)
  );

  jk_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_clr (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .btn_i   (iBtnClr),
    .level_o (lvl_clr),
    .rise_o  (rise_clr)
  );

  assign other_rise = (pend_q == CMD_SET) ? rise_clr : rise_set;

  // The command is registered on the same edge that enters EMIT, so the
  // pulse lines up exactly with the single EMIT cycle.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wcnt_d  = wcnt_q;
    jk_d    = CMD_HOLD;
    case (state_q)
      IDLE: begin
        if (rise_set && rise_clr) begin
          state_d = EMIT;
          jk_d    = CMD_TGL;
        end else if (rise_set) begin
          state_d = PAIR;
          pend_d  = CMD_SET;
          wcnt_d  = '0;
        end else if (rise_clr) begin
          state_d = PAIR;
          pend_d  = CMD_CLR;
          wcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      PAIR: begin
        if ((PAIR_WINDOW > 0) && other_rise) begin
          state_d = EMIT;
          jk_d    = CMD_TGL;
        end else if ((PAIR_WINDOW == 0) || (wcnt_q == WIN_LAST)) begin
          state_d = EMIT;
          jk_d    = pend_q;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      EMIT: begin
        state_d = LOCK;
      end
      LOCK: begin
        if (!lvl_set && !lvl_clr) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == PAIR) || (state_d == LOCK);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      pend_q  <= CMD_HOLD;
      wcnt_q  <= '0;
      jk_q    <= CMD_HOLD;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
      jk_q    <= jk_d;
      busy_q  <= busy_d;
    end
  end

  assign oJ    = jk_q[1];
  assign oK    = jk_q[0];
  assign oBusy = busy_q;

endmodule

// File: tb/tb_jk_cmd_gen.sv
// Self-checking bench for jk_cmd_gen: directed scenarios plus a long random
// run, all compared against a cycle-indexed reference model of the press rules.
module tb_jk_cmd_gen;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int PW   = 8;
  localparam int NCYC = 6000;

  logic clk = 1'b0;
  logic rst;
  logic bset;
  logic bclr;
  logic oj;
  logic ok;
  logic obusy;

  always #5 clk = ~clk;

  jk_cmd_gen #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .PAIR_WINDOW     (PW)
  ) dut (
    .iClk    (clk),
    .iRst    (rst),
    .iBtnSet (bset),
    .iBtnClr (bclr),
    .oJ      (oj),
    .oK      (ok),
    .oBusy   (obusy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-cycle history: raw inputs as driven, and the model's debounced levels.
  bit raw_s [NCYC];
  bit raw_c [NCYC];
  bit rst_h [NCYC];
  bit lv_s  [NCYC];
  bit lv_c  [NCYC];

  int         r_start;
  bit         waiting;
  bit         locked;
  bit         pend_set;
  int         pend_e;
  int         pulse_at;
  logic [1:0] pulse_cmd;
  logic       exp_j;
  logic       exp_k;
  logic       exp_b;

  function automatic bit sync_at(input bit is_set, input int x);
    if (x - SYNC < r_start) return 1'b0;
    return is_set ? raw_s[x-SYNC] : raw_c[x-SYNC];
  endfunction

  // A level changes once the synchronised input has disagreed with it for
  // DEB consecutive cycles since reset.
  function automatic bit level_at(input bit is_set, input int c);
    bit prev;
    prev = is_set ? lv_s[c-1] : lv_c[c-1];
    if (c - DEB < r_start) return prev;
    for (int k = 1; k <= DEB; k++) begin
      if (sync_at(is_set, c - k) == prev) return prev;
    end
    return ~prev;
  endfunction

  task automatic model_step(input int c);
    bit ev_s;
    bit ev_c;
    logic [1:0] jk;
    if (c == 0 || rst_h[c-1]) begin
      r_start  = c;
      lv_s[c]  = 1'b0;
      lv_c[c]  = 1'b0;
      waiting  = 1'b0;
      locked   = 1'b0;
      pulse_at = -1;
      ev_s     = 1'b0;
      ev_c     = 1'b0;
    end else begin
      lv_s[c] = level_at(1'b1, c);
      lv_c[c] = level_at(1'b0, c);
      ev_s    = lv_s[c] && !lv_s[c-1];
      ev_c    = lv_c[c] && !lv_c[c-1];
    end
    jk    = (pulse_at == c) ? pulse_cmd : 2'b00;
    exp_j = jk[1];
    exp_k = jk[0];
    exp_b = waiting || locked;
    if (pulse_at == c) begin
      locked = 1'b1;
    end else if (locked) begin
      if (!lv_s[c] && !lv_c[c]) locked = 1'b0;
    end else if (waiting) begin
      if (PW > 0 && (pend_set ? ev_c : ev_s)) begin
        pulse_at = c + 1; pulse_cmd = 2'b11; waiting = 1'b0;
      end else if (c >= pend_e + PW) begin
        pulse_at = c + 1; pulse_cmd = pend_set ? 2'b10 : 2'b01; waiting = 1'b0;
      end
    end else if (ev_s && ev_c) begin
      pulse_at = c + 1; pulse_cmd = 2'b11;
    end else if (ev_s || ev_c) begin
      waiting = 1'b1; pend_set = ev_s; pend_e = c;
    end
  endtask

  task automatic tick(input bit s, input bit cl, input bit r);
    bset = s; bclr = cl; rst = r;
    raw_s[cyc] = s; raw_c[cyc] = cl; rst_h[cyc] = r;
    @(posedge clk);
    #1;
    cyc++;
    model_step(cyc);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    total++;
    if ({oj, ok, obusy} !== 3'b000) begin
      bad++; $display("FAIL reset got=%b exp=000", {oj, ok, obusy});
    end
  endtask

  task automatic test_set_press();
    int first = -1; int npulse = 0; logic [1:0] fcmd = 2'b00;
    tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);
    for (int k = 2; k < 60; k++) begin
      tick(k < 40, 1'b0, 1'b0);
      total++;
      if ({oj, ok, obusy} !== {exp_j, exp_k, exp_b}) begin
        bad++; $display("FAIL set_press cyc=%0d got=%b exp=%b", k + 1, {oj, ok, obusy}, {exp_j, exp_k, exp_b});
      end
      if (k + 1 == 8 || k + 1 == 9) begin
        total++;
        if (obusy !== (k + 1 == 9)) begin
          bad++; $display("FAIL set_busy cyc=%0d got=%b exp=%b", k + 1, obusy, (k + 1 == 9));
        end
      end
      if (oj | ok) begin npulse++; if (first < 0) begin first = k + 1; fcmd = {oj, ok}; end end
    end
    total++;
    if (first != 17 || fcmd !== 2'b10 || npulse != 1) begin
      bad++; $display("FAIL set_pulse got cyc=%0d cmd=%b n=%0d exp cyc=17 cmd=10 n=1", first, fcmd, npulse);
    end
  endtask

  task automatic test_toggle_merge();
    int first = -1; int npulse = 0; logic [1:0] fcmd = 2'b00;
    tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);
    for (int k = 2; k < 60; k++) begin
      tick(k < 40, k >= 5 && k < 40, 1'b0);
      total++;
      if ({oj, ok, obusy} !== {exp_j, exp_k, exp_b}) begin
        bad++; $display("FAIL toggle cyc=%0d got=%b exp=%b", k + 1, {oj, ok, obusy}, {exp_j, exp_k, exp_b});
      end
      if (oj | ok) begin npulse++; if (first < 0) begin first = k + 1; fcmd = {oj, ok}; end end
    end
    total++;
    if (first != 12 || fcmd !== 2'b11 || npulse != 1) begin
      bad++; $display("FAIL toggle_pulse got cyc=%0d cmd=%b n=%0d exp cyc=12 cmd=11 n=1", first, fcmd, npulse);
    end
  endtask

  task automatic test_window_miss();
    int first = -1; int last = -1; int npulse = 0;
    logic [1:0] fcmd = 2'b00; logic [1:0] lcmd = 2'b00;
    tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);
    for (int k = 2; k < 100; k++) begin
      tick(k < 40, (k >= 20 && k < 45) || (k >= 60 && k < 80), 1'b0);
      total++;
      if ({oj, ok, obusy} !== {exp_j, exp_k, exp_b}) begin
        bad++; $display("FAIL window_miss cyc=%0d got=%b exp=%b", k + 1, {oj, ok, obusy}, {exp_j, exp_k, exp_b});
      end
      if (oj | ok) begin
        npulse++; last = k + 1; lcmd = {oj, ok};
        if (first < 0) begin first = k + 1; fcmd = {oj, ok}; end
      end
    end
    total++;
    if (first != 17 || fcmd !== 2'b10 || last != 75 || lcmd !== 2'b01 || npulse != 2) begin
      bad++; $display("FAIL window_pulses got %0d:%b %0d:%b n=%0d exp 17:10 75:01 n=2", first, fcmd, last, lcmd, npulse);
    end
  endtask

  task automatic test_bounce();
    int nz = 0;
    tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);
    for (int k = 2; k < 40; k++) begin
      tick(k < 22 && ((k - 2) % 4 != 3), 1'b0, 1'b0);
      total++;
      if ({oj, ok, obusy} !== {exp_j, exp_k, exp_b}) begin
        bad++; $display("FAIL bounce cyc=%0d got=%b exp=%b", k + 1, {oj, ok, obusy}, {exp_j, exp_k, exp_b});
      end
      if (oj | ok | obusy) nz++;
    end
    total++;
    if (nz != 0) begin
      bad++; $display("FAIL bounce_quiet active_cycles=%0d exp=0", nz);
    end
  endtask

  task automatic test_simultaneous();
    int first = -1; int npulse = 0; logic [1:0] fcmd = 2'b00;
    tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);
    for (int k = 2; k < 45; k++) begin
      tick(k < 30, k < 30, 1'b0);
      total++;
      if ({oj, ok, obusy} !== {exp_j, exp_k, exp_b}) begin
        bad++; $display("FAIL simultaneous cyc=%0d got=%b exp=%b", k + 1, {oj, ok, obusy}, {exp_j, exp_k, exp_b});
      end
      if (oj | ok) begin npulse++; if (first < 0) begin first = k + 1; fcmd = {oj, ok}; end end
    end
    total++;
    if (first != 9 || fcmd !== 2'b11 || npulse != 1) begin
      bad++; $display("FAIL simul_pulse got cyc=%0d cmd=%b n=%0d exp cyc=9 cmd=11 n=1", first, fcmd, npulse);
    end
  endtask

  task automatic test_reset_mid_pair();
    int first = -1; int npulse = 0; logic [1:0] fcmd = 2'b00;
    tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);
    for (int k = 2; k < 50; k++) begin
      tick(k < 45, 1'b0, k == 12);
      total++;
      if ({oj, ok, obusy} !== {exp_j, exp_k, exp_b}) begin
        bad++; $display("FAIL reset_pair cyc=%0d got=%b exp=%b", k + 1, {oj, ok, obusy}, {exp_j, exp_k, exp_b});
      end
      if (oj | ok) begin npulse++; if (first < 0) begin first = k + 1; fcmd = {oj, ok}; end end
    end
    total++;
    if (first != 28 || fcmd !== 2'b10 || npulse != 1) begin
      bad++; $display("FAIL reset_pair_pulse got cyc=%0d cmd=%b n=%0d exp cyc=28 cmd=10 n=1", first, fcmd, npulse);
    end
  endtask

  task automatic test_random();
    bit s = 1'b0; bit cl = 1'b0; bit r;
    int hold_s = 0; int hold_c = 0; bit prev_pulse = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (hold_s == 0) begin s = $urandom_range(0, 1) == 1; hold_s = $urandom_range(1, 30); end
      if (hold_c == 0) begin cl = $urandom_range(0, 2) == 0; hold_c = $urandom_range(1, 30); end
      hold_s--; hold_c--;
      r = ($urandom_range(0, 399) == 0);
      tick(s, cl, r);
      total++;
      if ({oj, ok, obusy} !== {exp_j, exp_k, exp_b}) begin
        bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {oj, ok, obusy}, {exp_j, exp_k, exp_b});
      end
      if (prev_pulse && (oj | ok)) begin
        bad++; $display("FAIL random_double cyc=%0d got=%b exp=00", cyc, {oj, ok});
      end
      prev_pulse = oj | ok;
    end
  endtask

  initial begin
    rst = 1'b1; bset = 1'b0; bclr = 1'b0;
    @(posedge clk);
    #1;
    model_step(0);
    test_reset();
    test_set_press();
    test_toggle_merge();
    test_window_miss();
    test_bounce();
    test_simultaneous();
    test_reset_mid_pair();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_cmd_gen.md
Name: jk_cmd_gen

Overview:
Front-end command stage that sits directly upstream of the JK flip-flop and drives its iJ/iK inputs from two raw push-buttons, SET and CLR.
- Each button is synchronised and debounced.
- A press of SET alone issues a one-cycle set command (J=1,K=0).
- A press of CLR alone issues a one-cycle clear command (J=0,K=1).
- Two presses landing within a pairing window merge into a toggle command (J=1,K=1).
- When no command is issued, the outputs hold J=0,K=0.

Parameters:
SYNC_STAGES, 2, synchroniser flops per button (min 2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a level change (min 1)
PAIR_WINDOW, 1000, cycles after a first press during which a second press merges into a toggle; 0 disables merging except for simultaneous edges

Ports:
iClk  input  1  system clock, all logic on rising edge
iRst  input  1  synchronous, active-high reset
iBtnSet  input  1  raw asynchronous SET button, active high
iBtnClr  input  1  raw asynchronous CLR button, active high
oJ  output  1  J command to the flip-flop, registered, one-cycle pulse
oK  output  1  K command to the flip-flop, registered, one-cycle pulse
oBusy  output  1  high while in PAIR or LOCK state

Behaviour:
- One clock domain: iClk. Reset is synchronous, active-high, on iRst.
- Reset values: oJ=0, oK=0, oBusy=0, all synchroniser flops 0, debounced levels 0, debounce counters 0, FSM=IDLE.
- Synchroniser: SYNC_STAGES-flop chain per button.
- Debounce, per channel:
  - The counter increments each cycle the synchronised input differs from the debounced level.
  - The counter clears to 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no level change.
- Edge event: debounced level rising, i.e. level=1 and level in the previous cycle=0. An event is valid for one cycle.
- IDLE:
  - Both events in the same cycle → EMIT toggle.
  - A single event → PAIR. The pending button is recorded and the window counter is set to 0.
- PAIR:
  - The window counter increments each cycle.
  - The other button's event arrives while count<PAIR_WINDOW → EMIT toggle.
  - Count reaches PAIR_WINDOW → EMIT the pending command.
  - A repeated event from the pending button is ignored.
  - If PAIR_WINDOW=0, PAIR lasts exactly one cycle and always emits the pending command.
- EMIT:
  - oJ/oK are driven for exactly one cycle: set=10, clear=01, toggle=11.
  - Next state is LOCK.
- LOCK:
  - All events are ignored.
  - Return to IDLE when both debounced levels are 0.
- Latency:
  - Single press, event at cycle E: pulse visible in cycle E+PAIR_WINDOW+1.
  - Pair with second event at cycle F: pulse in cycle F+1.
  - Simultaneous events at E: toggle pulse in cycle E+1.
  - Raw to event: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Output rules: oJ and oK are never high for more than one consecutive cycle. The value 00 means hold.
- Reset mid-operation:
  - Any pending or in-flight command is discarded; no pulse is emitted.
  - A button still held after reset re-qualifies through debounce and generates a fresh event.
- Width rule: counters are sized with $clog2(param+1); none ever wraps.

Decomposition:
Shared package jk_pkg holds:
- The FSM state enum: IDLE, PAIR, EMIT, LOCK.
- The command encodings: CMD_HOLD=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_TGL=2'b11, with bit1→oJ and bit0→oK.

One sub-module, jk_debounce, holds the synchroniser, debounce counter and rise-edge detector for one channel. It is instantiated twice.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PAIR_WINDOW=8, iRst high cycles 0-1, inputs change just after edges):
- SET press: iBtnSet high from cycle 2 and held, CLR low → event at cycle 8; oJ=1,oK=0 only in cycle 17; oBusy 1 from cycle 9 until LOCK exits; no further pulse while held.
- Toggle merge: SET high from cycle 2, CLR high from cycle 5 → CLR event at 11 (<8+8); oJ=1,oK=1 only in cycle 12.
- Window miss: SET high from cycle 2, CLR high from cycle 20 → set pulse (10) in cycle 17; CLR ignored while SET still held (LOCK); after both released, a new CLR press gives 01.
- Bounce reject: iBtnSet pulses high for 3 cycles, repeated 5 times with 1-cycle gaps → oJ, oK and oBusy stay 0 throughout.
- Simultaneous: both buttons high from cycle 2 → toggle pulse (11) in cycle 9.
- Reset mid-PAIR: SET event at 8, iRst asserted cycle 12 for 1 cycle, SET held → no pulse at 17; re-qualified event at cycle 19, oJ pulse in cycle 28.
